alu_arbiter: RTL and testbench

- Shares one combinational RV32 ALU core between NUM_REQ requesters, for example the integer execute path and the address-generation path.
- Each requester uses a valid/ready handshake; grants are round-robin.
- The arbiter drives the ALU operands and ALUop, then captures result and zero flag in a one-entry output register with valid/ready backpressure.
- It sits between the decode stage(s) and writeback, replacing the direct decode-to-ALU connection.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_core.sv | 36 +++
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the RV32 ALU datapath width, the ALUop field width, the supported
// ALUop encodings and the output-register state type.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 6;

  localparam logic [OPW-1:0] ALU_ADD  = 6'b000001;
  localparam logic [OPW-1:0] ALU_SUB  = 6'b000010;
  localparam logic [OPW-1:0] ALU_SLL  = 6'b000011;
  localparam logic [OPW-1:0] ALU_SRL  = 6'b001011;
  localparam logic [OPW-1:0] ALU_AND  = 6'b000110;
  localparam logic [OPW-1:0] ALU_OR   = 6'b000111;
  localparam logic [OPW-1:0] ALU_XOR  = 6'b001000;
  localparam logic [OPW-1:0] ALU_ADDI = 6'b000101;

  // Occupancy of the one-entry result register.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the
// result consumer.
//   req_valid/req_ready : per-requester handshake (one bit per requester)
//   req_op1/req_op2     : packed operands, requester i at [i*XLEN +: XLEN]
//   req_aluop           : packed ALUop, requester i at [i*OPW +: OPW]
//   rsp_valid/rsp_ready : output register handshake
//   rsp_id/result/zero/err : payload of the held result
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int OPW     = 6,
  parameter int IDW     = 2
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_op1;
  logic [NUM_REQ*XLEN-1:0] req_op2;
  logic [NUM_REQ*OPW-1:0]  req_aluop;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [XLEN-1:0]         rsp_result;
  logic                    rsp_zero;
  logic                    rsp_err;

  modport master (
    output req_valid, req_op1, req_op2, req_aluop, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_aluop, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational RV32 ALU shared by all requesters.
//   op1, op2 : operands (XLEN bits)
//   aluop    : operation select (OPW bits)
//   result   : operation result, 0 for unsupported codes
//   zero     : result == 0
//   err      : aluop is not one this core implements (jal/branch/lw/sw
//              codes are resolved elsewhere and land here as errors)
module alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [OPW-1:0]  aluop,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (aluop)
      ALU_ADD, ALU_ADDI: result = op1 + op2;
      ALU_SUB:           result = op1 - op2;
      // Shift amount is the low five bits only, as in RV32.
      ALU_SLL:           result = op1 << op2[4:0];
      ALU_SRL:           result = op1 >> op2[4:0];
      ALU_AND:           result = op1 & op2;
      ALU_OR:            result = op1 | op2;
      ALU_XOR:           result = op1 ^ op2;
      default:           err    = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ
// requesters, with a one-entry registered result and valid/ready
// backpressure on the output.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : alu_arbiter_if slave modport (requests in, result out)
//   grant_cnt : number of accepted requests, wraps at 16 bits
// Parameters: NUM_REQ (2..4), XLEN (must be 32 to match alu_core),
// OPW, IDW (2**IDW >= NUM_REQ).
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int OPW     = 6,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [15:0]       grant_cnt
);

  import alu_pkg::*;

  out_state_t       state;
  logic [IDW-1:0]   rr_ptr;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             can_accept;
  logic             accept;

  logic [XLEN-1:0]  sel_op1_p0;
  logic [XLEN-1:0]  sel_op2_p0;
  logic [OPW-1:0]   sel_aluop_p0;
  logic [XLEN-1:0]  alu_res_p0;
  logic             alu_zero_p0;
  logic             alu_err_p0;

  logic             vld_p1;
  logic [IDW-1:0]   id_p1;
  logic [XLEN-1:0]  res_p1;
  logic             zero_p1;
  logic             err_p1;

  // ---- Stage p0: winner selection, operand mux, combinational ALU ----

  // The result register can take a new value when empty, or when the
  // held result leaves in this same cycle.
  assign can_accept = (state == OUT_EMPTY) | bus.rsp_ready;

  // Search order starts at rr_ptr and wraps. Position k of the search
  // maps to index m when rr_ptr + k equals m, or m + NUM_REQ after wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int m = 0; m < NUM_REQ; m++) begin
        if (!gnt_found && bus.req_valid[m] &&
            ((int'(rr_ptr) + k == m) || (int'(rr_ptr) + k == m + NUM_REQ))) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(m);
        end
      end
    end
  end

  // Ready is offered only to the winner, so it depends on a requester's
  // own valid only through the winner choice.
  always_comb begin
    bus.req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_ready[k] = gnt_found && (gnt_idx == IDW'(k)) && can_accept;
    end
  end

  assign accept = gnt_found & can_accept;

  always_comb begin
    sel_op1_p0   = '0;
    sel_op2_p0   = '0;
    sel_aluop_p0 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        sel_op1_p0   = bus.req_op1[k*XLEN +: XLEN];
        sel_op2_p0   = bus.req_op2[k*XLEN +: XLEN];
        sel_aluop_p0 = bus.req_aluop[k*OPW +: OPW];
      end
    end
  end

  alu_core u_core (
    .op1    (sel_op1_p0),
    .op2    (sel_op2_p0),
    .aluop  (sel_aluop_p0),
    .result (alu_res_p0),
    .zero   (alu_zero_p0),
    .err    (alu_err_p0)
  );

  // ---- Stage p1: output register and round-robin pointer ----

  // An accept always fills the register, whether it was empty or is
  // being drained this cycle, so back-to-back results have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OUT_EMPTY;
      vld_p1    <= 1'b0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
      id_p1     <= '0;
      res_p1    <= '0;
      zero_p1   <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      if (accept) begin
        state     <= OUT_FULL;
        vld_p1    <= 1'b1;
        id_p1     <= gnt_idx;
        res_p1    <= alu_res_p0;
        zero_p1   <= alu_zero_p0;
        err_p1    <= alu_err_p0;
        rr_ptr    <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        grant_cnt <= grant_cnt + 16'd1;
      end else if ((state == OUT_FULL) && bus.rsp_ready) begin
        state  <= OUT_EMPTY;
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_id     = id_p1;
  assign bus.rsp_result = res_p1;
  assign bus.rsp_zero   = zero_p1;
  assign bus.rsp_err    = err_p1;

  // A waiting requester must hold its operands until it is accepted.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_stable
    a_req_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
      (bus.req_valid[i] && !bus.req_ready[i]) |=>
        (!bus.req_valid[i] ||
         ($stable(bus.req_op1[i*XLEN +: XLEN]) &&
          $stable(bus.req_op2[i*XLEN +: XLEN]) &&
          $stable(bus.req_aluop[i*OPW +: OPW])))
    );
  end

  // A stalled result stays put until the consumer takes it.
  a_rsp_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (vld_p1 && !bus.rsp_ready) |=>
      (vld_p1 && $stable(id_p1) && $stable(res_p1) &&
       $stable(zero_p1) && $stable(err_p1))
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] grant_cnt;

  int total = 0;
  int bad   = 0;

  alu_arbiter_if #(.NUM_REQ(2), .XLEN(32), .OPW(6), .IDW(2)) bus ();

  alu_arbiter #(.NUM_REQ(2), .XLEN(32), .OPW(6), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_cnt (grant_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int i, input logic v, input logic [31:0] a,
                     input logic [31:0] b, input logic [5:0] op);
    if (i == 0) begin
      bus.req_valid[0]     = v;
      bus.req_op1[31:0]    = a;
      bus.req_op2[31:0]    = b;
      bus.req_aluop[5:0]   = op;
    end else begin
      bus.req_valid[1]     = v;
      bus.req_op1[63:32]   = a;
      bus.req_op2[63:32]   = b;
      bus.req_aluop[11:6]  = op;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [31:0] res,
                         input logic zero, input logic err);
    chk({tag, "_vld"},  32'(bus.rsp_valid),  32'h1);
    chk({tag, "_id"},   32'(bus.rsp_id),     32'(id));
    chk({tag, "_res"},  bus.rsp_result,      res);
    chk({tag, "_zero"}, 32'(bus.rsp_zero),   32'(zero));
    chk({tag, "_err"},  32'(bus.rsp_err),    32'(err));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_aluop = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_vld",  32'(bus.rsp_valid),  32'h0);
    chk("rst_id",   32'(bus.rsp_id),     32'h0);
    chk("rst_res",  bus.rsp_result,      32'h0);
    chk("rst_zero", 32'(bus.rsp_zero),   32'h0);
    chk("rst_err",  32'(bus.rsp_err),    32'h0);
    chk("rst_cnt",  32'(grant_cnt),      32'h0);
    rst_n = 1'b1;

    // Test 1: single add on requester 0
    drv(0, 1'b1, 32'd5, 32'd7, 6'b000001);
    bus.rsp_ready = 1'b1;
    #1;
    chk("t1_rdy", 32'(bus.req_ready), 32'h1);
    tick();
    drv(0, 1'b0, 32'd0, 32'd0, 6'b000000);
    chk_rsp("t1", 2'd0, 32'd12, 1'b0, 1'b0);
    chk("t1_cnt", 32'(grant_cnt), 32'd1);

    // Requester 1 alone (addi) moves the pointer back to 0
    drv(1, 1'b1, 32'h10, 32'h20, 6'b000101);
    #1;
    chk("t1b_rdy", 32'(bus.req_ready), 32'h2);
    tick();
    drv(1, 1'b0, 32'd0, 32'd0, 6'b000000);
    chk_rsp("t1b", 2'd1, 32'h30, 1'b0, 1'b0);

    // Test 2: both valid every cycle, grants alternate with no bubbles
    drv(0, 1'b1, 32'd3, 32'd3, 6'b000010);
    drv(1, 1'b1, 32'hF0, 32'h0F, 6'b001000);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_rdy", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      if (k % 2 == 0) chk_rsp("t2_r0", 2'd0, 32'h0, 1'b1, 1'b0);
      else            chk_rsp("t2_r1", 2'd1, 32'hFF, 1'b0, 1'b0);
    end
    chk("t2_cnt", 32'(grant_cnt), 32'd6);

    // Test 3: output full and stalled, requester 1 waits
    bus.rsp_ready = 1'b0;
    drv(0, 1'b0, 32'd0, 32'd0, 6'b000000);
    drv(1, 1'b1, 32'hA0, 32'h05, 6'b000111);
    #1;
    chk("t3_rdy0", 32'(bus.req_ready), 32'h0);
    tick();
    chk_rsp("t3_hold", 2'd1, 32'hFF, 1'b0, 1'b0);
    chk("t3_rdy1", 32'(bus.req_ready), 32'h0);
    chk("t3_cnt0", 32'(grant_cnt), 32'd6);
    tick();
    chk("t3_hold2", bus.rsp_result, 32'hFF);
    bus.rsp_ready = 1'b1;
    #1;
    chk("t3_rdy2", 32'(bus.req_ready), 32'h2);
    tick();
    drv(1, 1'b0, 32'd0, 32'd0, 6'b000000);
    chk_rsp("t3_or", 2'd1, 32'hA5, 1'b0, 1'b0);
    chk("t3_cnt1", 32'(grant_cnt), 32'd7);

    // Test 4: shifts, sub wrap, unsupported op
    drv(0, 1'b1, 32'd1, 32'h25, 6'b000011);
    tick();
    chk_rsp("t4_sll", 2'd0, 32'h20, 1'b0, 1'b0);
    drv(0, 1'b1, 32'd0, 32'd1, 6'b000010);
    tick();
    chk_rsp("t4_sub", 2'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    drv(0, 1'b1, 32'h80000000, 32'h3F, 6'b001011);
    tick();
    chk_rsp("t4_srl", 2'd0, 32'h1, 1'b0, 1'b0);
    drv(0, 1'b1, 32'h0000FF0F, 32'h000000F3, 6'b000110);
    tick();
    chk_rsp("t4_and", 2'd0, 32'h3, 1'b0, 1'b0);
    drv(0, 1'b1, 32'd9, 32'd3, 6'b000100);
    tick();
    chk_rsp("t4_bad", 2'd0, 32'h0, 1'b1, 1'b1);
    chk("t4_cnt", 32'(grant_cnt), 32'd12);

    // Test 5: asynchronous reset while the output is full
    drv(0, 1'b0, 32'd0, 32'd0, 6'b000000);
    bus.rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_vld", 32'(bus.rsp_valid), 32'h0);
    chk("t5_cnt", 32'(grant_cnt),     32'h0);
    chk("t5_res", bus.rsp_result,     32'h0);
    chk("t5_err", 32'(bus.rsp_err),   32'h0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    drv(0, 1'b1, 32'd2, 32'd2, 6'b000001);
    drv(1, 1'b1, 32'd3, 32'd3, 6'b000001);
    #1;
    chk("t5_rdy", 32'(bus.req_ready), 32'h1);
    tick();
    chk_rsp("t5_first", 2'd0, 32'd4, 1'b0, 1'b0);
    chk("t5_cnt1", 32'(grant_cnt), 32'd1);

    // Test 6: grant counter wrap
    drv(1, 1'b0, 32'd0, 32'd0, 6'b000000);
    drv(0, 1'b1, 32'd1, 32'd2, 6'b000001);
    repeat (16'hFFFE) tick();
    chk("t6_max", 32'(grant_cnt), 32'hFFFF);
    tick();
    chk("t6_wrap", 32'(grant_cnt), 32'h0);
    chk_rsp("t6_res", 2'd0, 32'd3, 1'b0, 1'b0);
    drv(0, 1'b0, 32'd0, 32'd0, 6'b000000);
    tick();
    chk("t6_drain", 32'(bus.rsp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
